// File: rtl/mainboard_wb_arbiter.sv
// Two-master Wishbone arbiter for the mainboard's 8-bit slave port. The bus is
// held for a whole cyc-framed transaction, and priority rotates between grants.
// If the slave does not ack a strobe within TIMEOUT cycles, the owner gets err.
// Ports: clk/reset_n; m0_*/m1_* master-side Wishbone (adr/dat/we/sel/stb/cyc in,
//        dat/ack/err out); s_* slave-side Wishbone; grant one-hot owner ([0]=m0).
module mainboard_wb_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:23] m0_adr_i,
  input  logic [0:7]  m0_dat_i,
  output logic [0:7]  m0_dat_o,
  input  logic        m0_we_i,
  input  logic [0:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [0:23] m1_adr_i,
  input  logic [0:7]  m1_dat_i,
  output logic [0:7]  m1_dat_o,
  input  logic        m1_we_i,
  input  logic [0:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [0:23] s_adr_o,
  output logic [0:7]  s_dat_o,
  input  logic [0:7]  s_dat_i,
  output logic        s_we_o,
  output logic [0:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  output logic [0:1]  grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam bit TO_EN = (TIMEOUT != 0);

  state_t             state, state_nxt;
  logic               last, last_nxt;       // 0: m0 owned last, 1: m1 owned last
  logic [TO_BITS-1:0] to_cnt, to_cnt_nxt;
  logic               own, own_stb, to_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last   <= 1'b1;                         // m0 wins the first tie
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  // grant is a pure decode of the state register, so it is glitch-free.
  assign grant = {state == OWN0, state == OWN1};

  always_comb begin
    own     = (state == OWN0) || (state == OWN1);
    own_stb = (state == OWN0) ? m0_stb_i : (state == OWN1) ? m1_stb_i : 1'b0;
    // An ack arriving in the final cycle takes precedence over the timeout.
    to_hit  = TO_EN && own && own_stb && !s_ack_i &&
              (to_cnt == TO_BITS'(TIMEOUT - 1));
    if (!TO_EN || !own || !own_stb || s_ack_i || to_hit) begin
      to_cnt_nxt = '0;
    end else begin
      to_cnt_nxt = to_cnt + TO_BITS'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus steering. In IDLE, the slave sees an all-zero bus and neither master
  // sees any response. This includes a stray slave ack arriving after reset.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !to_hit;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = to_hit;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !to_hit;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = to_hit;
      end
      default: ;
    endcase
  end

endmodule
